// File: rtl/jump_ctl_pkg.sv
// Shared definitions for the jump controller.
//   state_e           : controller states (2-bit encoding)
//   SIDE_LEFT/RIGHT   : platform / key side encoding
//   SCORE_W_DEF       : default score counter width
//   IDLE_TIMEOUT_MS_DEF : default idle timeout in ms
//   cnt_width()       : bits needed to hold 0..max_val
package jump_ctl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_JUMP = 2'd1,
    S_FALL = 2'd2,
    S_OVER = 2'd3
  } state_e;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  localparam int SCORE_W_DEF         = 10;
  localparam int IDLE_TIMEOUT_MS_DEF = 3000;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/jump_ctl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    : clock
//   clr_i  : synchronous clear (has priority over increment)
//   inc_i  : increment by one, holds at all-ones
//   cnt_o  : current count (registered)
module jump_ctl_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/jump_ctl.sv
// Jump controller: turns key pulses into one-cycle jump commands for the
// character block, scores landed hops and declares game over after a fall.
// Optional feature macro: JUMP_IDLE_TIMEOUT_EN (automatic fail after
// IDLE_TIMEOUT_MS ms with a platform pending and no key press).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   module_en         : low behaves exactly like rst
//   one_ms_tick       : 1 ms pulse (timeout feature only)
//   key_left/right    : debounced press pulses
//   landed            : hop/fall finished pulse from the character block
//   next_valid/side   : next platform side from the generator
//   next_ack          : consumes next_side
//   jump_left/right/fail : one-cycle commands
//   score, score_tick : saturating hop count and increment pulse
//   game_over         : level, held until reset
//
// state  | meaning
// S_IDLE | waiting for a key with a platform pending
// S_JUMP | correct jump issued, waiting for landed to score
// S_FALL | fall issued, waiting for landed to end the game
// S_OVER | terminal, only reset leaves
module jump_ctl
  import jump_ctl_pkg::*;
#(
  parameter int SCORE_W         = SCORE_W_DEF,
  parameter int IDLE_TIMEOUT_MS = IDLE_TIMEOUT_MS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               module_en,
  input  logic               one_ms_tick,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               landed,
  input  logic               next_valid,
  input  logic               next_side,
  output logic               next_ack,
  output logic               jump_left,
  output logic               jump_right,
  output logic               jump_fail,
  output logic [SCORE_W-1:0] score,
  output logic               score_tick,
  output logic               game_over
);

  state_e state_q, state_d;

  logic clr_all;
  logic key_one, key_side, take, side_match, timeout_hit;
  logic jump_left_q,  jump_left_d;
  logic jump_right_q, jump_right_d;
  logic jump_fail_q,  jump_fail_d;
  logic next_ack_q,   next_ack_d;
  logic score_tick_q, score_tick_d;
  logic game_over_q,  game_over_d;

  assign clr_all    = rst | ~module_en;

  // A press counts only when exactly one key is down and a platform is pending.
  assign key_one    = key_left ^ key_right;
  assign key_side   = key_right ? SIDE_RIGHT : SIDE_LEFT;
  assign take       = (state_q == S_IDLE) && key_one && next_valid;
  assign side_match = (key_side == next_side);

`ifdef JUMP_IDLE_TIMEOUT_EN
  localparam int TMO_W = cnt_width(IDLE_TIMEOUT_MS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TIMEOUT_MS - 1);

  logic             ms_inc;
  logic [TMO_W-1:0] ms_cnt;

  assign ms_inc = (state_q == S_IDLE) && next_valid && one_ms_tick;

  jump_ctl_sat_counter #(.W(TMO_W)) u_idle_cnt (
    .clk   (clk),
    .clr_i (clr_all || (state_q != S_IDLE)),
    .inc_i (ms_inc),
    .cnt_o (ms_cnt)
  );

  // Fires on the tick that brings the count to IDLE_TIMEOUT_MS; a valid
  // key press in the same cycle takes precedence.
  assign timeout_hit = ms_inc && (ms_cnt == TMO_LAST) && !take;
`else
  logic unused_tmo;
  assign unused_tmo  = one_ms_tick ^ (IDLE_TIMEOUT_MS == 0);
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr_all) begin
      state_q      <= S_IDLE;
      jump_left_q  <= 1'b0;
      jump_right_q <= 1'b0;
      jump_fail_q  <= 1'b0;
      next_ack_q   <= 1'b0;
      score_tick_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      jump_left_q  <= jump_left_d;
      jump_right_q <= jump_right_d;
      jump_fail_q  <= jump_fail_d;
      next_ack_q   <= next_ack_d;
      score_tick_q <= score_tick_d;
      game_over_q  <= game_over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take)             state_d = side_match ? S_JUMP : S_FALL;
        else if (timeout_hit) state_d = S_FALL;
      end
      S_JUMP:  if (landed) state_d = S_IDLE;
      S_FALL:  if (landed) state_d = S_OVER;
      default: state_d = S_OVER;
    endcase
  end

  always_comb begin
    jump_left_d  = take && side_match && (key_side == SIDE_LEFT);
    jump_right_d = take && side_match && (key_side == SIDE_RIGHT);
    jump_fail_d  = (take && !side_match) || timeout_hit;
    next_ack_d   = take || timeout_hit;
    score_tick_d = (state_q == S_JUMP) && landed;
    game_over_d  = game_over_q || ((state_q == S_FALL) && landed);
  end

  jump_ctl_sat_counter #(.W(SCORE_W)) u_score_cnt (
    .clk   (clk),
    .clr_i (clr_all),
    .inc_i (score_tick_d),
    .cnt_o (score)
  );

  assign jump_left  = jump_left_q;
  assign jump_right = jump_right_q;
  assign jump_fail  = jump_fail_q;
  assign next_ack   = next_ack_q;
  assign score_tick = score_tick_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_jump_ctl.sv
module tb_jump_ctl;

  localparam int SW  = 2;
  localparam int TMO = 5;
  localparam int SMAX = (1 << SW) - 1;

  localparam int PH_WAIT = 0;
  localparam int PH_HOP  = 1;
  localparam int PH_DROP = 2;
  localparam int PH_DEAD = 3;

  logic clk = 1'b0;
  logic rst, module_en, one_ms_tick, key_left, key_right, landed;
  logic next_valid, next_side;
  logic next_ack, jump_left, jump_right, jump_fail, score_tick, game_over;
  logic [SW-1:0] score;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  int m_phase = PH_WAIT;
  int m_score = 0;
  int m_over  = 0;
  int m_ms    = 0;
  logic e_jl, e_jr, e_fail, e_ack, e_tick;

  always #5 clk = ~clk;

  jump_ctl #(.SCORE_W(SW), .IDLE_TIMEOUT_MS(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .module_en   (module_en),
    .one_ms_tick (one_ms_tick),
    .key_left    (key_left),
    .key_right   (key_right),
    .landed      (landed),
    .next_valid  (next_valid),
    .next_side   (next_side),
    .next_ack    (next_ack),
    .jump_left   (jump_left),
    .jump_right  (jump_right),
    .jump_fail   (jump_fail),
    .score       (score),
    .score_tick  (score_tick),
    .game_over   (game_over)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  // One decision cycle of the game rules, from the current inputs.
  task automatic model_step();
    int presses;
    e_jl = 0; e_jr = 0; e_fail = 0; e_ack = 0; e_tick = 0;
    if (rst || !module_en) begin
      m_phase = PH_WAIT; m_score = 0; m_over = 0; m_ms = 0;
      return;
    end
    presses = int'(key_left) + int'(key_right);
    case (m_phase)
      PH_WAIT: begin
        if (presses == 1 && next_valid) begin
          e_ack = 1;
          m_ms = 0;
          if (int'(key_right) == int'(next_side)) begin
            if (key_right) e_jr = 1; else e_jl = 1;
            m_phase = PH_HOP;
          end else begin
            e_fail = 1;
            m_phase = PH_DROP;
          end
        end
`ifdef JUMP_IDLE_TIMEOUT_EN
        else if (next_valid && one_ms_tick) begin
          m_ms++;
          if (m_ms >= TMO) begin
            e_fail = 1; e_ack = 1; m_ms = 0;
            m_phase = PH_DROP;
          end
        end
`endif
      end
      PH_HOP: if (landed) begin
        e_tick = 1;
        if (m_score < SMAX) m_score++;
        m_phase = PH_WAIT;
      end
      PH_DROP: if (landed) begin
        m_over = 1;
        m_phase = PH_DEAD;
      end
      default: ;
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("jump_left",  jump_left,  e_jl);
    check("jump_right", jump_right, e_jr);
    check("jump_fail",  jump_fail,  e_fail);
    check("next_ack",   next_ack,   e_ack);
    check("score_tick", score_tick, e_tick);
    check("score",      score,      m_score);
    check("game_over",  game_over,  m_over);
  endtask

  task automatic drive(input logic l, input logic r, input logic land,
                       input logic nv, input logic side, input logic tick);
    key_left = l; key_right = r; landed = land;
    next_valid = nv; next_side = side; one_ms_tick = tick;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1, 1, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    drive(0, 0, 0, 0, 0, 0);
    rst = 0;
  endtask

  initial begin
    rst = 1; module_en = 1;
    key_left = 0; key_right = 0; landed = 0;
    next_valid = 0; next_side = 0; one_ms_tick = 0;

    // reset state
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("rst_score", score, 0);
    check("rst_over", game_over, 0);
    rst = 0;

    // matching right press, then land and score
    idle(8);
    drive(0, 1, 0, 1, 1, 0);
    check("hop_jr", jump_right, 1);
    check("hop_ack", next_ack, 1);
    idle(1);
    check("hop_jr_once", jump_right, 0);
    drive(0, 1, 0, 1, 1, 0);
    check("drop_key_in_jump", next_ack, 0);
    idle(5);
    drive(0, 0, 1, 1, 1, 0);
    check("hop_score", score, 1);
    check("hop_tick", score_tick, 1);

    // both keys / key without valid: ignored
    drive(1, 1, 0, 1, 0, 0);
    check("both_keys", next_ack, 0);
    drive(1, 0, 0, 0, 0, 0);
    check("no_valid", next_ack, 0);
    drive(1, 0, 0, 1, 0, 0);
    check("left_hop", jump_left, 1);

    // reset while airborne, later landed ignored, next key works
    idle(2);
    rst = 1; drive(0, 0, 0, 1, 1, 0); rst = 0;
    check("midrst_score", score, 0);
    drive(0, 0, 1, 1, 1, 0);
    check("late_land_tick", score_tick, 0);
    drive(0, 1, 0, 1, 1, 0);
    check("after_rst_jr", jump_right, 1);
    drive(0, 0, 1, 1, 1, 0);
    check("after_rst_score", score, 1);

    // saturation: five hops on a 2-bit score
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 1, 1, 0);
      idle(2);
      drive(0, 0, 1, 1, 1, 0);
      check("sat_score", score, (i + 1 > SMAX) ? SMAX : i + 1);
      check("sat_tick", score_tick, 1);
    end

    // wrong side -> fall -> game over, then frozen
    drive(0, 1, 0, 1, 0, 0);
    check("wrong_fail", jump_fail, 1);
    check("wrong_ack", next_ack, 1);
    idle(3);
    drive(0, 0, 1, 1, 0, 0);
    check("over_set", game_over, 1);
    drive(1, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    check("over_frozen", score, SMAX);
    check("over_held", game_over, 1);
    module_en = 0; drive(0, 0, 0, 1, 0, 0); module_en = 1;
    check("en_clears", game_over, 0);

`ifdef JUMP_IDLE_TIMEOUT_EN
    do_reset();
    for (int i = 0; i < TMO; i++) begin
      drive(0, 0, 0, 1, 1, 1);
      if (i < TMO - 1) idle(2);
    end
    check("tmo_fail", jump_fail, 1);
    check("tmo_ack", next_ack, 1);
    do_reset();
    for (int i = 0; i < TMO - 1; i++) begin
      drive(0, 0, 0, 1, 1, 1);
      idle(1);
    end
    drive(0, 1, 0, 1, 1, 1);
    check("tmo_key_wins", jump_right, 1);
    check("tmo_key_nofail", jump_fail, 0);
`endif

    // randomized play against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 9));
      rst       = ($urandom_range(0, 299) == 0);
      module_en = ($urandom_range(0, 299) != 0);
      drive(r < 2, (r >= 1) && (r < 4), $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0);
    end
    rst = 0; module_en = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
